fsm_seq_gen: RTL and testbench
==============================

Name: fsm_seq_gen

Overview:
- Parametrised Moore sequencer and the successor to the fixed 7-state output-pattern FSMs.
- Waits for a selectable trigger bit on ptext, then plays a parameter-defined output pattern on rtext, optionally repeated.
- Signals busy and done, and supports a synchronous abort.
- Sits between the plaintext-side control inputs and the response/obfuscation output logic.

Parameters:
- IN_W, 2: ptext width.
- OUT_W, 3: rtext width.
- TRIG_BIT, 1: index of the ptext bit that triggers a run. Must satisfy 0 <= TRIG_BIT < IN_W.
- NUM_PH, 5: number of output phases per pass. Must be >= 1.
- PATTERN, {3'b100,3'b100,3'b000,3'b000,3'b010}: NUM_PH*OUT_W bits. Phase k output is PATTERN[k*OUT_W +: OUT_W], so phase 0 sits in the LSBs.
- IDLE_OUT, 3'b000: rtext value in INIT, WAIT and DONE.
- REPEAT_W, 4: width of rep_cnt.
- TIMEOUT, 16: WAIT timeout in cycles. Used only with the optional feature. Must be >= 1.

Ports:
- CLK  in  1: clock. All logic is on the rising edge.
- RST_N  in  1: synchronous, active-low reset.
- en  in  1: permits the INIT->WAIT transition.
- ptext  in  IN_W: control input; bit TRIG_BIT is the trigger.
- rep_cnt  in  REPEAT_W: number of extra passes (total passes = rep_cnt+1). Sampled at trigger.
- abort  in  1: synchronous return to INIT.
- rtext  out  OUT_W: sequenced output.
- phase  out  PH_W: current phase index. PH_W = max(1, $clog2(NUM_PH)).
- busy  out  1: high in RUN.
- done  out  1: high for exactly one cycle, in DONE.
- timeout  out  1: one-cycle pulse on WAIT timeout. Tied 0 when the optional feature is off.

Behaviour:
- Outputs are a pure function of the registered state, phase and counters (Moore). There is no combinational path from any input to any output.
- Reset (RST_N=0 at a CLK edge) sets:
  - state=INIT, phase=0, pass counter=0, timeout counter=0;
  - therefore rtext=IDLE_OUT, busy=0, done=0, timeout=0.
- Reset is honoured in any state, including mid-RUN, and takes priority over all inputs.
- States:
  - INIT: if en=1, go to WAIT; otherwise stay in INIT.
  - WAIT: if ptext[TRIG_BIT]=1, go to RUN with phase=0 and pass counter=rep_cnt. Otherwise stay in WAIT.
  - RUN: rtext=PATTERN[phase]. While phase<NUM_PH-1, phase increments.
    - At phase=NUM_PH-1 with pass counter>0: decrement the pass counter, set phase=0, stay in RUN.
    - At phase=NUM_PH-1 with pass counter=0: go to DONE.
  - DONE: done=1, go to INIT unconditionally.
- Latency:
  - A trigger sampled in WAIT at edge t produces phase-0 output after edge t, i.e. in the next cycle.
  - RUN lasts exactly (rep_cnt+1)*NUM_PH cycles. DONE follows immediately.
- NUM_PH=1: every RUN cycle is the last phase, and phase stays 0.
- en is examined only in INIT. Deasserting en in WAIT or RUN has no effect.
- ptext is ignored outside WAIT. rep_cnt is ignored except at the WAIT->RUN edge.
- abort=1 in WAIT, RUN or DONE: go to INIT next cycle and clear phase and all counters.
  - abort outranks a trigger in the same cycle.
  - abort in DONE still lets done=1 show for that cycle.
  - abort in INIT has no effect beyond staying in INIT when en=0. If en=1 with abort=1, stay in INIT.
- State encoding: 2-bit binary from the package. Unreachable encodings go to INIT.

Optional Feature:
- Macro: FSM_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and is cleared on entry to WAIT.
  - If TIMEOUT consecutive WAIT cycles pass without a trigger, go to INIT and pulse timeout=1 for one cycle, in the first INIT cycle.
  - A trigger in the same cycle the count reaches TIMEOUT wins, so the block goes to RUN.
- Undefined: no counter is built, WAIT is unbounded, and timeout=0 constantly.

Decomposition:
- Package fsm_seq_pkg holds:
  - state typedef with ST_INIT=2'd0, ST_WAIT=2'd1, ST_RUN=2'd2, ST_DONE=2'd3;
  - localparam STATE_W=2;
  - function for PH_W.
- One sub-module: fsm_seq_phase_ctr.
  - Holds the phase and pass counters.
  - Inputs: load, advance, clear.
  - Outputs: phase, last_phase, last_pass.

Test Plan:
- Reset then en=1, ptext=2'b10, rep_cnt=0 (defaults) -> INIT, WAIT, then rtext=010,000,000,100,100 on consecutive cycles. busy=1 for 5 cycles, then done=1 for 1 cycle with rtext=000, then INIT.
- Same stimulus with rep_cnt=2 -> the 5-value pattern appears 3 times back-to-back (15 busy cycles), phase wraps 4->0 twice, and a single done pulse follows.
- abort=1 at RUN phase 2 -> next cycle is INIT with rtext=000, phase=0, busy=0, and no done pulse.
- Hold ptext=2'b01 (trigger bit 0) in WAIT for 40 cycles -> stays in WAIT with rtext=000. With FSM_SEQ_TIMEOUT_EN, after 16 cycles go to INIT with timeout=1 for one cycle.
- RST_N=0 for one edge at RUN phase 3 with rep_cnt=5 -> all outputs reset next cycle. After release, a fresh run starts from phase 0 with no leftover passes.
- Parameter sweep NUM_PH=1, OUT_W=8, IN_W=4, TRIG_BIT=3 -> a single-phase pattern repeats rep_cnt+1 cycles, and the trigger responds only to ptext[3].

Source files
------------

// File: rtl/fsm_seq_pkg.sv
// Shared state encoding and width helpers for the fsm_seq_gen sequencer.
package fsm_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // A single-phase pattern still needs a 1-bit phase port.
  function automatic int calc_ph_w(input int num_ph);
    return (num_ph <= 1) ? 1 : $clog2(num_ph);
  endfunction

endpackage

// File: rtl/fsm_seq_phase_ctr.sv
// Phase and pass counters for fsm_seq_gen: load starts a run, advance steps one
// RUN cycle, clear returns both counters to zero.
module fsm_seq_phase_ctr
  import fsm_seq_pkg::*;
#(
  parameter int NUM_PH   = 5,
  parameter int REPEAT_W = 4,
  parameter int PH_W     = calc_ph_w(NUM_PH)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                load,
  input  logic                advance,
  input  logic                clear,
  input  logic [REPEAT_W-1:0] rep_cnt,
  output logic [PH_W-1:0]     phase,
  output logic                last_phase,
  output logic                last_pass
);

  localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PH - 1);

  logic [PH_W-1:0]     phase_q, phase_d;
  logic [REPEAT_W-1:0] pass_q, pass_d;

  always_comb begin
    phase_d = phase_q;
    pass_d  = pass_q;
    if (clear) begin
      phase_d = '0;
      pass_d  = '0;
    end else if (load) begin
      phase_d = '0;
      pass_d  = rep_cnt;
    end else if (advance) begin
      // Wrapping at the last phase consumes one extra pass, if any remain.
      if (phase_q == LAST_PH) begin
        phase_d = '0;
        if (pass_q != '0) pass_d = pass_q - 1'b1;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      phase_q <= '0;
      pass_q  <= '0;
    end else begin
      phase_q <= phase_d;
      pass_q  <= pass_d;
    end
  end

  assign phase      = phase_q;
  assign last_phase = (phase_q == LAST_PH);
  assign last_pass  = (pass_q == '0);

endmodule

// File: rtl/fsm_seq_gen.sv
// Moore sequencer: waits for ptext[TRIG_BIT], then plays PATTERN (rep_cnt+1 passes).
// Optional WAIT timeout is built when FSM_SEQ_TIMEOUT_EN is defined.
module fsm_seq_gen
  import fsm_seq_pkg::*;
#(
  parameter int                         IN_W     = 2,
  parameter int                         OUT_W    = 3,
  parameter int                         TRIG_BIT = 1,
  parameter int                         NUM_PH   = 5,
  parameter logic [NUM_PH*OUT_W-1:0]    PATTERN  = {3'b100, 3'b100, 3'b000, 3'b000, 3'b010},
  parameter logic [OUT_W-1:0]           IDLE_OUT = '0,
  parameter int                         REPEAT_W = 4,
  parameter int                         TIMEOUT  = 16
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         en,
  input  logic [IN_W-1:0]              ptext,
  input  logic [REPEAT_W-1:0]          rep_cnt,
  input  logic                         abort,
  output logic [OUT_W-1:0]             rtext,
  output logic [calc_ph_w(NUM_PH)-1:0] phase,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout
);

  localparam int PH_W = calc_ph_w(NUM_PH);

  if (TRIG_BIT < 0 || TRIG_BIT >= IN_W || NUM_PH < 1 || TIMEOUT < 1) begin : g_param_check
    $error("fsm_seq_gen: illegal parameter combination");
  end

  state_e          state_q, state_d;
  logic            load, advance, clear;
  logic            last_phase, last_pass;
  logic [PH_W-1:0] ph_cnt;
  logic            trig;
  logic            tmo_hit;
  logic            unused_ptext;

  assign trig         = ptext[TRIG_BIT];
  assign unused_ptext = ^ptext;

`ifdef FSM_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_pulse_q, tmo_pulse_d;

  // Counter is zero outside WAIT, so every entry to WAIT starts from zero.
  assign tmo_hit     = (state_q == ST_WAIT) && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
  assign tmo_cnt_d   = (state_q == ST_WAIT && state_d == ST_WAIT) ? tmo_cnt_q + 1'b1 : '0;
  assign tmo_pulse_d = tmo_hit && !trig && !abort;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tmo_cnt_q   <= '0;
      tmo_pulse_q <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_pulse_q <= tmo_pulse_d;
    end
  end

  assign timeout = tmo_pulse_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  fsm_seq_phase_ctr #(
    .NUM_PH   (NUM_PH),
    .REPEAT_W (REPEAT_W),
    .PH_W     (PH_W)
  ) u_phase_ctr (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .load       (load),
    .advance    (advance),
    .clear      (clear),
    .rep_cnt    (rep_cnt),
    .phase      (ph_cnt),
    .last_phase (last_phase),
    .last_pass  (last_pass)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  // Abort outranks a trigger; the timeout only fires when neither is present.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    clear   = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (en && !abort) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (abort) begin
          state_d = ST_INIT;
          clear   = 1'b1;
        end else if (trig) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end else if (tmo_hit) begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_INIT;
          clear   = 1'b1;
        end else begin
          advance = 1'b1;
          if (last_phase && last_pass) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_INIT;
        clear   = abort;
      end
      default: begin
        state_d = ST_INIT;
        clear   = 1'b1;
      end
    endcase
  end

  always_comb begin
    rtext = IDLE_OUT;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      ST_RUN: begin
        rtext = PATTERN[int'(ph_cnt)*OUT_W +: OUT_W];
        busy  = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign phase = ph_cnt;

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Scoreboard bench for fsm_seq_gen: default instance plus a NUM_PH=1, 8-bit, TRIG_BIT=3 instance.
module tb_fsm_seq_gen;

  localparam int NUM_PH  = 5;
  localparam int TIMEOUT = 16;

  logic       CLK = 1'b0;
  logic       RST_N, en, abort;
  logic [1:0] ptext;
  logic [3:0] rep_cnt;
  logic [2:0] rtext;
  logic [2:0] phase;
  logic       busy, done, timeout;

  logic       en2, abort2;
  logic [3:0] ptext2, rep2;
  logic [7:0] rtext2;
  logic [0:0] phase2;
  logic       busy2, done2, timeout2;

  always #5 CLK = ~CLK;

  fsm_seq_gen dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .en      (en),
    .ptext   (ptext),
    .rep_cnt (rep_cnt),
    .abort   (abort),
    .rtext   (rtext),
    .phase   (phase),
    .busy    (busy),
    .done    (done),
    .timeout (timeout)
  );

  fsm_seq_gen #(
    .IN_W     (4),
    .OUT_W    (8),
    .TRIG_BIT (3),
    .NUM_PH   (1),
    .PATTERN  (8'hA5),
    .IDLE_OUT (8'h00)
  ) dut2 (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .en      (en2),
    .ptext   (ptext2),
    .rep_cnt (rep2),
    .abort   (abort2),
    .rtext   (rtext2),
    .phase   (phase2),
    .busy    (busy2),
    .done    (done2),
    .timeout (timeout2)
  );

  typedef struct {
    int         cyc;
    logic [7:0] rt;
    int         ph;
    bit         isDone;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t m1, m2;
  logic [2:0] pat [NUM_PH] = '{3'b010, 3'b000, 3'b000, 3'b100, 3'b100};
  int   checks = 0;
  int   errors = 0;
  int   cycleCnt = 0;
  int   tmoPulses = 0;
  int   tmoCyc = -1;
  bit   monEn = 1'b0;

  always @(posedge CLK) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: a run is passes*phases cycles of pattern[i % phases], then one done cycle.
  task automatic expectRun(input int sel, input int c0, input int passes, input int keep);
    int   nph = (sel == 1) ? NUM_PH : 1;
    int   len = passes * nph;
    exp_t e;
    for (int i = 0; i < len && i < keep; i++) begin
      e.cyc    = c0 + 1 + i;
      e.ph     = i % nph;
      e.rt     = (sel == 1) ? {5'b0, pat[i % nph]} : 8'hA5;
      e.isDone = 1'b0;
      if (sel == 1) q1.push_back(e); else q2.push_back(e);
    end
    if (keep > len) begin
      e.cyc    = c0 + 1 + len;
      e.ph     = 0;
      e.rt     = 8'h00;
      e.isDone = 1'b1;
      if (sel == 1) q1.push_back(e); else q2.push_back(e);
    end
  endtask

  always @(negedge CLK) begin
    if (monEn) begin
      if (timeout) begin
        tmoPulses++;
        tmoCyc = cycleCnt;
      end
      if (busy || done) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output actual busy=%b done=%b rtext=%b expected idle", busy, done, rtext);
        end else begin
          m1 = q1.pop_front();
          checkOutput("cycle", cycleCnt, m1.cyc);
          checkOutput("rtext", {29'b0, rtext}, {24'b0, m1.rt});
          checkOutput("phase", {29'b0, phase}, m1.ph);
          checkOutput("busy", {31'b0, busy}, {31'b0, !m1.isDone});
          checkOutput("done", {31'b0, done}, {31'b0, m1.isDone});
        end
      end else begin
        checkOutput("idle_rtext", {29'b0, rtext}, 0);
        checkOutput("idle_phase", {29'b0, phase}, 0);
      end
    end
  end

  always @(negedge CLK) begin
    if (monEn) begin
      checkOutput("dut2_timeout", {31'b0, timeout2}, 0);
      if (busy2 || done2) begin
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL dut2_unexpected_output actual busy=%b done=%b expected idle", busy2, done2);
        end else begin
          m2 = q2.pop_front();
          checkOutput("dut2_cycle", cycleCnt, m2.cyc);
          checkOutput("dut2_rtext", {24'b0, rtext2}, {24'b0, m2.rt});
          checkOutput("dut2_phase", {31'b0, phase2}, m2.ph);
          checkOutput("dut2_done", {31'b0, done2}, {31'b0, m2.isDone});
        end
      end else begin
        checkOutput("dut2_idle_rtext", {24'b0, rtext2}, 0);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic randomizeIgnored();
    ptext   = 2'($urandom);
    rep_cnt = 4'($urandom);
    en      = 1'($urandom);
  endtask

  // mode: 0 full run, 1 abort at RUN cycle k, 2 abort in DONE, 3 abort in WAIT, 4 reset at RUN cycle k
  task automatic applyStimulus(input int reps, input int mode, input int k);
    int len = (reps + 1) * NUM_PH;
    int c0;
    int keep;
    en    = 1'b1;
    ptext = {1'b0, 1'($urandom)};
    tick();
    en = 1'($urandom);
    repeat ($urandom_range(0, 6)) begin
      ptext = {1'b0, 1'($urandom)};
      tick();
    end
    if (mode == 3) begin
      abort = 1'b1;
      ptext = 2'b10;
      tick();
    end else begin
      ptext   = {1'b1, 1'($urandom)};
      rep_cnt = 4'(reps);
      c0      = cycleCnt;
      keep    = (mode == 1 || mode == 4) ? k + 1 : len + 1;
      expectRun(1, c0, reps + 1, keep);
      tick();
      if (mode == 1 || mode == 4) begin
        for (int i = 0; i < k; i++) begin
          randomizeIgnored();
          tick();
        end
        if (mode == 1) abort = 1'b1; else RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        if (mode == 4) begin
          @(negedge CLK);
          checkOutput("rst_rtext", {29'b0, rtext}, 0);
          checkOutput("rst_phase", {29'b0, phase}, 0);
          checkOutput("rst_busy", {31'b0, busy}, 0);
          checkOutput("rst_done", {31'b0, done}, 0);
        end
      end else if (mode == 2) begin
        for (int i = 0; i < len; i++) begin
          randomizeIgnored();
          tick();
        end
        abort = 1'b1;
        tick();
      end else begin
        for (int i = 0; i < len + 1; i++) begin
          randomizeIgnored();
          tick();
        end
      end
    end
    abort   = 1'b0;
    en      = 1'b0;
    ptext   = 2'b00;
    rep_cnt = 4'd0;
    tick();
  endtask

  task automatic runDut2(input int reps);
    int c0;
    en2    = 1'b1;
    ptext2 = 4'b0000;
    tick();
    en2 = 1'b0;
    repeat (4) begin
      ptext2 = 4'($urandom_range(0, 7));
      tick();
    end
    ptext2 = 4'b1000 | 4'($urandom_range(0, 7));
    rep2   = 4'(reps);
    c0     = cycleCnt;
    expectRun(2, c0, reps + 1, reps + 2);
    tick();
    ptext2 = 4'($urandom);
    rep2   = 4'($urandom);
    repeat (reps + 2) tick();
    ptext2 = 4'b0000;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cw;
    int mode;
    RST_N   = 1'b0;
    en      = 1'b0;
    abort   = 1'b0;
    ptext   = 2'b00;
    rep_cnt = 4'd0;
    en2     = 1'b0;
    abort2  = 1'b0;
    ptext2  = 4'b0000;
    rep2    = 4'd0;
    tick();
    tick();
    RST_N = 1'b1;
    @(negedge CLK);
    checkOutput("reset_rtext", {29'b0, rtext}, 0);
    checkOutput("reset_phase", {29'b0, phase}, 0);
    checkOutput("reset_busy", {31'b0, busy}, 0);
    checkOutput("reset_done", {31'b0, done}, 0);
    checkOutput("reset_timeout", {31'b0, timeout}, 0);
    monEn = 1'b1;

    applyStimulus(0, 0, 0);
    applyStimulus(2, 0, 0);
    applyStimulus(0, 1, 2);
    applyStimulus(5, 4, 3);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 2, 0);
    applyStimulus(0, 3, 0);

    en    = 1'b1;
    ptext = 2'b00;
    cw    = cycleCnt;
    tick();
    en    = 1'b0;
    ptext = 2'b01;
    repeat (40) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ptext = 2'b00;
    tick();
`ifdef FSM_SEQ_TIMEOUT_EN
    checkOutput("timeout_pulses", tmoPulses, 1);
    checkOutput("timeout_cycle", tmoCyc, cw + 1 + TIMEOUT);
`else
    checkOutput("timeout_pulses", tmoPulses, 0);
    checkOutput("timeout_cycle", tmoCyc, -1);
`endif

    for (int n = 0; n < 25; n++) begin
      mode = $urandom_range(0, 5);
      if (mode == 5) mode = 0;
      begin
        int reps = $urandom_range(0, 3);
        applyStimulus(reps, mode, $urandom_range(0, (reps + 1) * NUM_PH - 1));
      end
    end

    runDut2(0);
    runDut2(3);
    runDut2($urandom_range(1, 5));

    checkOutput("q1_drained", q1.size(), 0);
    checkOutput("q2_drained", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
